// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button pins in, debounced levels, event pulses and press count out.
// Rev 1.0
`default_nettype none

interface button_debouncer_if #(
   parameter int NBTN = 5
);
   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] press;
   logic [NBTN-1:0] rlse;
   logic [NBTN-1:0] long_press;
   logic [4:0]      press_count;

   modport master (
      output btn_raw,
      input  btn_level, press, rlse, long_press, press_count
   );

   modport slave (
      input  btn_raw,
      output btn_level, press, rlse, long_press, press_count
   );
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel 2-FF sync, debounce filter, press/release/long-press pulses.
// Rev 1.0
`default_nettype none

module button_debouncer #(
   parameter int NBTN          = 5,
   parameter int ACTIVE_LOW    = 1,
   parameter int STABLE_CYCLES = 250000,
   parameter int LONG_CYCLES   = 25000000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   button_debouncer_if.slave  btn_if
);

   localparam int DBW = $clog2(STABLE_CYCLES);
   localparam int HW  = $clog2(LONG_CYCLES + 1);
   localparam logic [DBW-1:0]  DB_MAX   = DBW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0]   HOLD_MAX = HW'(LONG_CYCLES);
   localparam logic [HW-1:0]   HOLD_PRE = HW'(LONG_CYCLES - 1);
   localparam logic [NBTN-1:0] POL      = (ACTIVE_LOW != 0) ? {NBTN{1'b1}} : {NBTN{1'b0}};

   logic [NBTN-1:0] sync1_q, sync2_q;
   logic [NBTN-1:0] level_q, level_d;
   logic [NBTN-1:0] press_q, press_d;
   logic [NBTN-1:0] rel_q, rel_d;
   logic [NBTN-1:0] long_q, long_d;
   logic [4:0]      count_q, count_d;
   logic [DBW-1:0]  db_q   [NBTN];
   logic [DBW-1:0]  db_d   [NBTN];
   logic [HW-1:0]   hold_q [NBTN];
   logic [HW-1:0]   hold_d [NBTN];

   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      long_d  = '0;
      for (int i = 0; i < NBTN; i++) begin
         db_d[i]   = '0;
         hold_d[i] = hold_q[i];
         if (sync2_q[i] != level_q[i]) begin
            if (db_q[i] == DB_MAX) begin
               level_d[i] = sync2_q[i];
            end else begin
               db_d[i] = db_q[i] + 1'b1;
            end
         end
         press_d[i] = level_d[i] & ~level_q[i];
         rel_d[i]   = ~level_d[i] & level_q[i];
         // Hold is still cleared on the edge the press registers, so it counts from that pulse.
         if (!level_q[i]) begin
            hold_d[i] = '0;
         end else if (hold_q[i] != HOLD_MAX) begin
            hold_d[i] = hold_q[i] + 1'b1;
         end
         long_d[i] = level_q[i] && (hold_q[i] == HOLD_PRE);
      end
      count_d = count_q + {4'd0, |press_q};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         long_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            db_q[i]   <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_if.btn_raw ^ POL;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
         count_q <= count_d;
         for (int i = 0; i < NBTN; i++) begin
            db_q[i]   <= db_d[i];
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign btn_if.btn_level   = level_q;
   assign btn_if.press       = press_q;
   assign btn_if.rlse        = rel_q;
   assign btn_if.long_press  = long_q;
   assign btn_if.press_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table-driven vectors plus directed multi-cycle sequences.
// Rev 1.0
`default_nettype none

module tb_button_debouncer;

   localparam int NBTN   = 2;
   localparam int STABLE = 4;
   localparam int LONG   = 10;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   button_debouncer_if #(.NBTN(NBTN)) bif ();

   button_debouncer #(
      .NBTN          (NBTN),
      .ACTIVE_LOW    (1),
      .STABLE_CYCLES (STABLE),
      .LONG_CYCLES   (LONG)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_if (bif.slave)
   );

   typedef struct {
      logic       rst;
      logic [1:0] raw;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
      logic [1:0] lng;
      logic [4:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [1:0] raw, input logic [1:0] lvl,
                               input logic [1:0] prs, input logic [1:0] rel,
                               input logic [1:0] lng, input logic [4:0] cnt);
      vec_t v;
      v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng; v.cnt = cnt;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Steps until the selected pulse (0 press, 1 long, 2 release) is seen or the budget runs out.
   task automatic wait_sig(input int which, input int max, output int n);
      logic [1:0] s;
      n = 0;
      do begin
         step();
         n++;
         case (which)
            0:       s = bif.press;
            1:       s = bif.long_press;
            default: s = bif.rlse;
         endcase
      end while (s == 2'b00 && n < max);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bif.btn_raw = 2'b11;

      repeat (3) add(1, 2'b11, 0, 0, 0, 0, 0);
      repeat (3) add(0, 2'b11, 0, 0, 0, 0, 0);
      // clean press on channel 0, then release
      repeat (5) add(0, 2'b10, 0, 0, 0, 0, 0);
      add(0, 2'b10, 2'b01, 2'b01, 0, 0, 0);
      add(0, 2'b10, 2'b01, 0, 0, 0, 1);
      repeat (5) add(0, 2'b11, 2'b01, 0, 0, 0, 1);
      add(0, 2'b11, 0, 0, 2'b01, 0, 1);
      add(0, 2'b11, 0, 0, 0, 0, 1);
      // bounce: low 3, high 1, then low steady and held into a long press
      repeat (3) add(0, 2'b10, 0, 0, 0, 0, 1);
      add(0, 2'b11, 0, 0, 0, 0, 1);
      repeat (5) add(0, 2'b10, 0, 0, 0, 0, 1);
      add(0, 2'b10, 2'b01, 2'b01, 0, 0, 1);
      repeat (9) add(0, 2'b10, 2'b01, 0, 0, 0, 2);
      add(0, 2'b10, 2'b01, 0, 0, 2'b01, 2);
      repeat (9) add(0, 2'b10, 2'b01, 0, 0, 0, 2);
      repeat (5) add(0, 2'b11, 2'b01, 0, 0, 0, 2);
      add(0, 2'b11, 0, 0, 2'b01, 0, 2);
      add(0, 2'b11, 0, 0, 0, 0, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst;
         bif.btn_raw = tbl[i].raw;
         step();
         chk($sformatf("vec%0d level", i), 32'(bif.btn_level),   32'(tbl[i].lvl));
         chk($sformatf("vec%0d press", i), 32'(bif.press),       32'(tbl[i].prs));
         chk($sformatf("vec%0d rel", i),   32'(bif.rlse),        32'(tbl[i].rel));
         chk($sformatf("vec%0d long", i),  32'(bif.long_press),  32'(tbl[i].lng));
         chk($sformatf("vec%0d count", i), 32'(bif.press_count), 32'(tbl[i].cnt));
      end

      // simultaneous press on both channels
      bif.btn_raw = 2'b00;
      wait_sig(0, 20, n);
      chk("simul latency", 32'(n), 32'(STABLE + 2));
      chk("simul press", 32'(bif.press), 32'h3);
      step();
      chk("simul count", 32'(bif.press_count), 32'd3);
      bif.btn_raw = 2'b11;
      wait_sig(2, 20, n);
      chk("simul release", 32'(bif.rlse), 32'h3);
      step();

      // wrap: 32 presses from a fresh reset
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      chk("wrap start", 32'(bif.press_count), 32'd0);
      for (int p = 1; p <= 32; p++) begin
         bif.btn_raw = (p % 2 == 0) ? 2'b01 : 2'b10;
         repeat (7) step();
         bif.btn_raw = 2'b11;
         repeat (7) step();
         chk($sformatf("wrap count%0d", p), 32'(bif.press_count), 32'(p % 32));
      end

      // reset in the middle of a hold
      bif.btn_raw = 2'b10;
      wait_sig(0, 20, n);
      chk("mid press latency", 32'(n), 32'(STABLE + 2));
      repeat (5) step();
      rst = 1'b1;
      step();
      chk("mid rst level", 32'(bif.btn_level),   32'd0);
      chk("mid rst long",  32'(bif.long_press),  32'd0);
      chk("mid rst count", 32'(bif.press_count), 32'd0);
      step();
      rst = 1'b0;
      wait_sig(0, 20, n);
      chk("post rst press", 32'(n), 32'(STABLE + 2));
      wait_sig(1, 20, n);
      chk("post rst long", 32'(n), 32'(LONG));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
